// File: rtl/rbz_dither_pkg.sv
// rbz_dither_pkg: shared Bayer matrix, mode encodings and scaled-LUT generator for ordered_dither
package rbz_dither_pkg;
  localparam logic [0:3][0:3][3:0] BAYER4 = {
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };
  localparam logic MODE_TRUNC   = 1'b0;
  localparam logic MODE_ORDERED = 1'b1;
  function automatic int dither_scale(input int v, input int in_bits, input int out_bits);
    int m;
    m = (1 << in_bits) - 1;
    return (v * ((1 << out_bits) - 1) * 16 + m / 2) / m;
  endfunction
endpackage

// File: rtl/dither_channel.sv
// dither_channel: combinational single-channel quantiser
// v_i value, t_i Bayer threshold, mode_i truncate/ordered, blank_i forces zero, out_o quantised value
module dither_channel
  import rbz_dither_pkg::*;
#(
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 1
) (
  input  logic [IN_BITS-1:0]  v_i,
  input  logic [3:0]          t_i,
  input  logic                mode_i,
  input  logic                blank_i,
  output logic [OUT_BITS-1:0] out_o
);
  localparam int SW = OUT_BITS + 4;
  logic [SW-1:0] lut [2**IN_BITS];
  logic [SW-1:0] s;
  for (genvar i = 0; i < 2**IN_BITS; i++) begin : g_lut
    assign lut[i] = SW'(dither_scale(i, IN_BITS, OUT_BITS));
  end
  assign s = lut[v_i];
  // top LUT entry has a zero fraction, so the increment never overflows
  assign out_o = blank_i ? '0 :
                 mode_i == MODE_ORDERED ? s[SW-1:4] + OUT_BITS'(s[3:0] > t_i) :
                 v_i[IN_BITS-1 -: OUT_BITS];
endmodule

// File: rtl/ordered_dither.sv
// ordered_dither: registered ordered-dither quantiser with sync pass-through and optional temporal field
// clk/reset pixel clock and sync active-high reset; mode truncate/ordered (sampled at reset and frame boundary)
// hpos_lo/vpos_lo pixel position LSBs; blank forces black; hsync_n_in/vsync_n_in active-low syncs
// rgb_in/rgb_out colour in/out; hsync_n_out/vsync_n_out delayed syncs; field temporal field
// ORDERED_DITHER_TEMPORAL_EN enables per-frame rotation of the threshold matrix
module ordered_dither
  import rbz_dither_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic [1:0]                   hpos_lo,
  input  logic [1:0]                   vpos_lo,
  input  logic                         blank,
  input  logic                         hsync_n_in,
  input  logic                         vsync_n_in,
  input  logic [CHANNELS*IN_BITS-1:0]  rgb_in,
  output logic [CHANNELS*OUT_BITS-1:0] rgb_out,
  output logic                         hsync_n_out,
  output logic                         vsync_n_out,
  output logic [1:0]                   field
);
  logic vs_prev_q, mode_q, hs_q, vs_q, fb;
  logic [1:0] xi, yi;
  logic [3:0] t;
  logic [CHANNELS*OUT_BITS-1:0] rgb_q, rgb_d;
  assign fb = vs_prev_q & ~vsync_n_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_q <= 1'b1;
      mode_q    <= mode;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rgb_q     <= '0;
    end else begin
      vs_prev_q <= vsync_n_in;
      mode_q    <= fb ? mode : mode_q;
      hs_q      <= hsync_n_in;
      vs_q      <= vsync_n_in;
      rgb_q     <= rgb_d;
    end
  end
`ifdef ORDERED_DITHER_TEMPORAL_EN
  logic [1:0] field_q;
  always_ff @(posedge clk) begin
    if (reset) field_q <= '0;
    else if (fb) field_q <= field_q + 2'd1;
  end
  assign field = field_q;
`else
  assign field = 2'b00;
`endif
  assign xi = hpos_lo ^ {2{field[0]}};
  assign yi = vpos_lo ^ {2{field[1]}};
  assign t  = BAYER4[yi][xi];
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    dither_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_ch (
      .v_i    (rgb_in[c*IN_BITS +: IN_BITS]),
      .t_i    (t),
      .mode_i (mode_q),
      .blank_i(blank),
      .out_o  (rgb_d[c*OUT_BITS +: OUT_BITS])
    );
  end
  assign rgb_out     = rgb_q;
  assign hsync_n_out = hs_q;
  assign vsync_n_out = vs_q;
endmodule

// File: tb/tb_ordered_dither.sv
// tb_ordered_dither: table-driven self-checking bench for ordered_dither
module tb_ordered_dither;
  logic clk = 1'b0;
  logic reset = 1'b0, mode = 1'b1, blank = 1'b0;
  logic [1:0] hpos_lo = '0, vpos_lo = '0;
  logic hsync_n_in = 1'b1, vsync_n_in = 1'b1;
  logic [5:0] rgb_in = '0;
  logic [2:0] rgb_out;
  logic hsync_n_out, vsync_n_out;
  logic [1:0] field;
  logic [3:0] rgb_in4 = '0;
  logic [1:0] rgb_out4;
  logic hs4, vs4;
  logic [1:0] field4;
  int tests = 0, fails = 0;
  int bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  typedef struct {
    logic       m;
    logic [5:0] rgb;
    logic [1:0] x, y;
    logic       bl;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  ordered_dither dut (
    .clk(clk), .reset(reset), .mode(mode), .hpos_lo(hpos_lo), .vpos_lo(vpos_lo),
    .blank(blank), .hsync_n_in(hsync_n_in), .vsync_n_in(vsync_n_in), .rgb_in(rgb_in),
    .rgb_out(rgb_out), .hsync_n_out(hsync_n_out), .vsync_n_out(vsync_n_out), .field(field)
  );
  ordered_dither #(.CHANNELS(1), .IN_BITS(4), .OUT_BITS(2)) dut4 (
    .clk(clk), .reset(reset), .mode(mode), .hpos_lo(hpos_lo), .vpos_lo(vpos_lo),
    .blank(blank), .hsync_n_in(hsync_n_in), .vsync_n_in(vsync_n_in), .rgb_in(rgb_in4),
    .rgb_out(rgb_out4), .hsync_n_out(hs4), .vsync_n_out(vs4), .field(field4)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset(input logic m);
    reset = 1'b1;
    mode = m;
    step();
    reset = 1'b0;
  endtask
  task automatic vfall();
    vsync_n_in = 1'b0;
    step();
    vsync_n_in = 1'b1;
    step();
  endtask
  function automatic logic [2:0] rep3(input bit b);
    return b ? 3'b111 : 3'b000;
  endfunction
  initial begin
    logic cur_mode;
    int fexp;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        vecs.push_back('{1'b1, 6'b101010, 2'(x), 2'(y), 1'b0, rep3(bay[y][x] < 11)});
        vecs.push_back('{1'b1, 6'b010101, 2'(x), 2'(y), 1'b0, rep3(bay[y][x] < 5)});
        vecs.push_back('{1'b1, 6'b111111, 2'(x), 2'(y), 1'b0, 3'b111});
        vecs.push_back('{1'b0, 6'b100110, 2'(x), 2'(y), 1'b0, 3'b101});
      end
    vecs.push_back('{1'b1, 6'b101010, 2'd2, 2'd1, 1'b0, 3'b000});
    vecs.push_back('{1'b1, 6'b101010, 2'd0, 2'd0, 1'b0, 3'b111});
    vecs.push_back('{1'b1, 6'b111111, 2'd1, 2'd2, 1'b1, 3'b000});
    vecs.push_back('{1'b0, 6'b111111, 2'd3, 2'd3, 1'b1, 3'b000});
    // reset state, with inputs that would otherwise produce non-reset outputs
    rgb_in = 6'b111111;
    hsync_n_in = 1'b0;
    do_reset(1'b1);
    check("reset_rgb", rgb_out, 0);
    check("reset_hs", hsync_n_out, 1);
    check("reset_vs", vsync_n_out, 1);
    check("reset_field", field, 0);
    hsync_n_in = 1'b1;
    cur_mode = 1'b1;
    foreach (vecs[i]) begin
      if (vecs[i].m != cur_mode) begin
        do_reset(vecs[i].m);
        cur_mode = vecs[i].m;
      end
      rgb_in = vecs[i].rgb;
      hpos_lo = vecs[i].x;
      vpos_lo = vecs[i].y;
      blank = vecs[i].bl;
      step();
      check($sformatf("vec%0d_rgb", i), rgb_out, vecs[i].exp);
    end
    blank = 1'b0;
    // 4-bit in / 2-bit out instance
    do_reset(1'b1);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        hpos_lo = 2'(x);
        vpos_lo = 2'(y);
        rgb_in4 = 4'd8;
        step();
        check($sformatf("w4_v8_%0d_%0d", x, y), rgb_out4, bay[y][x] < 10 ? 2 : 1);
        rgb_in4 = 4'd15;
        step();
        check($sformatf("w4_v15_%0d_%0d", x, y), rgb_out4, 3);
      end
    // sync pass-through with one cycle latency
    do_reset(1'b1);
    hsync_n_in = 1'b0;
    #1;
    check("hs_pre", hsync_n_out, 1);
    step();
    check("hs_fall", hsync_n_out, 0);
    hsync_n_in = 1'b1;
    step();
    check("hs_rise", hsync_n_out, 1);
    vsync_n_in = 1'b0;
    #1;
    check("vs_pre", vsync_n_out, 1);
    step();
    check("vs_fall", vsync_n_out, 0);
    vsync_n_in = 1'b1;
    step();
    check("vs_rise", vsync_n_out, 1);
    // mode change held off until after the frame boundary pixel
    do_reset(1'b1);
    rgb_in = 6'b101010;
    hpos_lo = 2'd2;
    vpos_lo = 2'd1;
    mode = 1'b0;
    step();
    check("mode_hold0", rgb_out, 0);
    step();
    check("mode_hold1", rgb_out, 0);
    vsync_n_in = 1'b0;
    step();
    check("mode_fb_pixel", rgb_out, 0);
    step();
    check("mode_switched", rgb_out, 7);
    vsync_n_in = 1'b1;
    step();
    check("mode_stays", rgb_out, 7);
    // field sequence across vsync falls
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      vfall();
`ifdef ORDERED_DITHER_TEMPORAL_EN
      fexp = (i + 1) % 4;
`else
      fexp = 0;
`endif
      check($sformatf("field_%0d", i), field, fexp);
    end
    // pixel (0,0) after one frame boundary
    vfall();
    rgb_in = 6'b010101;
    hpos_lo = 2'd0;
    vpos_lo = 2'd0;
    step();
`ifdef ORDERED_DITHER_TEMPORAL_EN
    check("field1_pix00", rgb_out, 0);
`else
    check("field1_pix00", rgb_out, 7);
`endif
    // mid-frame reset
    vfall();
    rgb_in = 6'b111111;
    reset = 1'b1;
    step();
    check("midreset_field", field, 0);
    check("midreset_rgb", rgb_out, 0);
    reset = 1'b0;
    step();
    check("postreset_rgb", rgb_out, 7);
    vfall();
`ifdef ORDERED_DITHER_TEMPORAL_EN
    check("postreset_field", field, 1);
`else
    check("postreset_field", field, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ordered_dither.md
# ordered_dither

Parametrised ordered-dither quantiser. It reduces CHANNELS colour channels of IN_BITS each to OUT_BITS each, using a 4×4 Bayer threshold matrix, and optionally adds per-frame temporal rotation of that matrix. It sits between the rbzero pixel source and the board's RGB pins, replacing the fixed 2→1-bit dither with a registered, sync-aligned stage that carries hsync_n/vsync_n through with matching latency.

## Interface
- CHANNELS, 3: number of colour channels; channel 0 occupies the LSBs (BBGGRR order).
- IN_BITS, 2: input bits per channel; legal range 2..6.
- OUT_BITS, 1: output bits per channel; legal range 1..IN_BITS-1.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- mode  in  1  0 = truncate, 1 = ordered dither; sampled at reset and at each frame boundary.
- hpos_lo  in  2  hpos[1:0] of the current pixel.
- vpos_lo  in  2  vpos[1:0] of the current pixel.
- blank  in  1  1 = outside the visible area; forces the output to 0.
- hsync_n_in, vsync_n_in  in  1 each  active-low syncs from vga_sync.
- rgb_in  in  CHANNELS*IN_BITS  pixel colour.
- rgb_out  out  CHANNELS*OUT_BITS  quantised colour.
- hsync_n_out, vsync_n_out  out  1 each  syncs delayed to match rgb_out.
- field  out  2  current temporal field.

## Operation
- Frame boundary (fb): vs_prev & ~vsync_n_in, where vs_prev is vsync_n_in registered (reset value 1).
- On fb: mode_q <= mode, and field <= field + 1 (wraps 3→0). Both take effect from the next cycle; the fb pixel itself uses the old values.
- Threshold: t = BAYER4[yi][xi].
  - Rows are y0: 0 8 2 10; y1: 12 4 14 6; y2: 3 11 1 9; y3: 15 7 13 5.
  - xi = hpos_lo ^ {2{field[0]}}, yi = vpos_lo ^ {2{field[1]}}.
- Per channel, with input value v:
  - scaled = (v·(2^OUT_BITS−1)·16 + ⌊(2^IN_BITS−1)/2⌋) / (2^IN_BITS−1).
  - scaled is OUT_BITS+4 bits wide and is an elaboration-time constant LUT indexed by v.
  - Ordered mode: out = scaled[OUT_BITS+3:4] + (scaled[3:0] > t). This cannot overflow, because at the maximum base level the fraction is 0.
  - Truncate mode: out = v[IN_BITS−1 : IN_BITS−OUT_BITS].
- blank = 1 gives out = 0 for all channels, in every mode.
- Reset and fb in the same cycle: reset wins.
- Reset mid-frame: the pipeline clears; the next fb then advances field from 0 to 1.

## Timing
- Latency is 1 cycle. rgb_out, hsync_n_out and vsync_n_out are all registered from the same-cycle inputs.
- Reset values:
  - rgb_out = 0, hsync_n_out = 1, vsync_n_out = 1.
  - field = 0, vs_prev = 1.
  - mode_q = mode as sampled in the reset cycle.
- Throughput is one pixel per clock. There is no stall or handshake.

## Configuration
- The macro is ORDERED_DITHER_TEMPORAL_EN.
- When defined: the field counter runs as described, and the field output reflects it.
- When undefined: the field register is not built, field is tied to 0, and xi/yi equal hpos_lo/vpos_lo. The dither pattern is purely spatial and identical every frame.

## Structure
- Package rbz_dither_pkg holds:
  - BAYER4 constant (4×4×4-bit).
  - MODE_TRUNC = 0 and MODE_ORDERED = 1.
  - Function dither_scale(v, in_bits, out_bits) that generates the scaled LUT.
- Sub-module dither_channel: the combinational per-channel quantiser (v, t, mode_q, blank → out), instantiated CHANNELS times by generate.
- The top level holds the sync pipeline, frame-boundary detection, mode_q and field.

## Test plan
- Defaults, mode = 1, rgb_in = 6'b101010, sweep hpos_lo/vpos_lo over the 4×4 grid → rgb_out = 3'b111 at exactly the 11 positions with t < 11 (e.g. 0 at (x=2, y=1), 1 at (0,0)), each one cycle after the input.
- Defaults, rgb_in = 6'b010101 → 3'b111 at the 5 positions with t < 5; rgb_in = 6'b111111 → 3'b111 at all 16 positions; mode = 0 with rgb_in = 6'b100110 → 3'b101 at every position.
- blank = 1 with rgb_in = 6'b111111 → rgb_out = 0. Syncs toggled → hsync_n_out and vsync_n_out follow exactly one cycle later.
- mode changed mid-frame → output keeps the old mode until the cycle after the next vsync_n_in falling edge.
- With ORDERED_DITHER_TEMPORAL_EN: 4 vsync falls → field goes 1, 2, 3, 0. At field = 1 the pixel (0,0) uses t = BAYER4[0][3] = 10. Reset asserted mid-frame → field = 0 and rgb_out = 0 on the next cycle.
- IN_BITS = 4, OUT_BITS = 2, v = 8 → scaled = 26, so out = 2 where t < 10 and 1 elsewhere; v = 15 → out = 3 everywhere.
